adder: RTL and testbench

Registered 32-bit two-operand adder with carry-in, used as the datapath adder of the 32-bit MIPS processor for PC increment, branch-target and ALU add paths. Sums `dataout1 + dataout2 + carryin` and registers the 32-bit result, carry-out and status flags one clock after the inputs are sampled.

---
 rtl/adder.sv | 83 ++++++++
 tb/tb_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// adder: registered WIDTH-bit carry-lookahead adder with carry-in, carry-out and status flags.
// Optional subtract mode when ADDER_SUB_EN is defined (adds the sub input).
module adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataout1,
    input  logic [WIDTH-1:0] dataout2,
    input  logic             carryin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic [WIDTH-1:0] resultofadd,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);
    logic [WIDTH-1:0] b_op, g, p, sum;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] result_d, result_q;
    logic             carryout_d, carryout_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

`ifdef ADDER_SUB_EN
    assign b_op = sub ? ~dataout2 : dataout2;
    assign c[0] = sub | carryin;
`else
    assign b_op = dataout2;
    assign c[0] = carryin;
`endif

    assign g   = dataout1 & b_op;
    assign p   = dataout1 ^ b_op;
    assign sum = p ^ c[WIDTH-1:0];

    // Lookahead inside each 4-bit group; the group carry-out ripples to the next group.
    genvar k;
    for (k = 0; k < WIDTH / 4; k++) begin : gen_cla
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    always_comb begin
        result_d    = in_valid ? sum : result_q;
        carryout_d  = in_valid ? c[WIDTH] : carryout_q;
        overflow_d  = in_valid ? (c[WIDTH] ^ c[WIDTH-1]) : overflow_q;
        zero_d      = in_valid ? (sum == '0) : zero_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign resultofadd = result_q;
    assign carryout    = carryout_q;
    assign overflow    = overflow_q;
    assign zero        = zero_q;
    assign out_valid   = out_valid_q;
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder; expected outputs queued at drive time, popped one cycle later.
module tb_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        logic         vld;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         carryin = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] resultofadd;
    logic         carryout, overflow, zero, out_valid;

    exp_t q[$];
    exp_t last = '0;
    exp_t e;
    exp_t obs;
    int   checks = 0;
    int   errors = 0;

    adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dataout1(a),
        .dataout2(b),
        .carryin(carryin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid),
        .resultofadd(resultofadd),
        .carryout(carryout),
        .overflow(overflow),
        .zero(zero),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign obs = {resultofadd, carryout, overflow, zero, out_valid};

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t         r;
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         cc;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.res = full[W-1:0];
        r.co  = full[W];
        r.ov  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        r.z   = (full[W-1:0] == '0);
        r.vld = 1'b1;
        return r;
    endfunction

    // Drives one cycle of stimulus, queues its expected outcome, returns #1 after the sampling edge.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input logic s);
        @(negedge clk);
        rst_n = r; in_valid = v; a = x; b = y; carryin = ci; sub = s;
        if (!r) last = '0;
        else if (v) last = model(x, y, ci, s);
        else last.vld = 1'b0;
        q.push_back(last);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
            e = q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset%0d: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] ta[4] = '{32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] tb[4] = '{32'h2, 32'h0, 32'h1, 32'h8000_0000};
        logic         tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t         fixed[4] = '{{32'h3, 1'b0, 1'b0, 1'b0, 1'b1}, {32'h0, 1'b1, 1'b0, 1'b1, 1'b1},
                                   {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1},
                                   {32'h0, 1'b1, 1'b1, 1'b1, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, ta[i], tb[i], tc[i], 1'b0);
            e = q.pop_front(); checks++;
            if (obs !== e || obs !== fixed[i]) begin
                errors++; $display("FAIL basic%0d: got %h expected %h", i, obs, fixed[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t fixed[4] = '{{32'd30, 1'b0, 1'b0, 1'b0, 1'b1}, {32'd70, 1'b0, 1'b0, 1'b0, 1'b1},
                           {32'd70, 1'b0, 1'b0, 1'b0, 1'b0}, {32'd70, 1'b0, 1'b0, 1'b0, 1'b0}};
        drive(1'b1, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = q.pop_front(); checks++;
            if (e !== fixed[i]) begin errors++; $display("FAIL b2b_model%0d: got %h expected %h", i, e, fixed[i]); end
        end
    endtask

    task automatic test_pipeline_observe;
        drive(1'b1, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL pipe_a: got %h expected %h", obs, e); end
        drive(1'b1, 1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL pipe_b: got %h expected %h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
            e = q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL hold%0d: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 1'b1, 32'd100, 32'd1, 1'b1, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL mid_pre: got %h expected %h", obs, e); end
        drive(1'b0, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL mid_rst: got %h expected %h", obs, e); end
        drive(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL mid_idle: got %h expected %h", obs, e); end
        drive(1'b1, 1'b1, 32'd4, 32'd6, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL mid_post: got %h expected %h", obs, e); end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            y = (i % 8 == 1) ? (~x + 32'h1) : $urandom;
            drive(1'b1, ($urandom_range(0, 3) != 0), x, y, 1'($urandom_range(0, 1)), 1'b0);
            e = q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL rand%0d: got %h expected %h", i, obs, e); end
        end
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub;
        exp_t fixed[2] = '{{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}, {32'd2, 1'b1, 1'b0, 1'b0, 1'b1}};
        drive(1'b1, 1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
        e = q.pop_front(); checks++;
        if (obs !== fixed[0] || e !== fixed[0]) begin errors++; $display("FAIL sub_5m7: got %h expected %h", obs, fixed[0]); end
        drive(1'b1, 1'b1, 32'd7, 32'd5, 1'b1, 1'b1);
        e = q.pop_front(); checks++;
        if (obs !== fixed[1] || e !== fixed[1]) begin errors++; $display("FAIL sub_7m5: got %h expected %h", obs, fixed[1]); end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL sub_rand%0d: got %h expected %h", i, obs, e); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_pipeline_observe;
        test_reset_midstream;
        test_random;
`ifdef ADDER_SUB_EN
        test_sub;
`endif
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
